// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op codes, FSM states and op decode helpers for the mul/div unit
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // Codes 0..3 are the iterative ops; everything else never enters RUN.
  function automatic logic op_is_muldiv(logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - start/busy/done request bus and HI/LO outputs of the mul/div unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, div0, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, div0, hi, lo);
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// rtl/mul_div_unit_sign_fix.sv - conditional two's-complement negate (abs-in / sign-out helper)
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? ('0 - i_val) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - bit-serial MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MTHI/MTLO
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opb, r_a_raw, r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_div0_pend, r_done, r_div0;

  logic               w_signed, w_is_div, w_take, w_accept;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix, w_mul_next, w_div_next;
  logic [WIDTH:0]     w_mul_sum, w_div_trial;

  assign w_signed = op_is_signed(bus.op);
  assign w_is_div = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
  assign w_take   = bus.start && !bus.flush && (r_state == MDU_IDLE);
  assign w_accept = w_take && op_is_muldiv(bus.op);

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.i_val(bus.a), .i_neg(w_signed && bus.a[WIDTH-1]), .o_val(w_abs_a));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.i_val(bus.b), .i_neg(w_signed && bus.b[WIDTH-1]), .o_val(w_abs_b));
  // Low half of the negated {rem,quot} word equals the negated quotient, so one 2W fixer serves both ops.
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val(r_prod), .i_neg(r_neg_q), .o_val(w_prod_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.i_val(r_prod[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem_fix));

  // Multiply: r_prod = {partial, multiplier}; add multiplicand on the low bit, shift right.
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_prod[0]}} & r_opb};
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Divide: r_prod = {remainder, dividend/quotient}; restoring trial subtract on a W+1 bit remainder.
  assign w_div_trial = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]} - {1'b0, r_opb};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= MDU_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_next = MDU_RUN;
      MDU_RUN: begin
        if (bus.flush)                                w_next = MDU_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))          w_next = MDU_FIN;
      end
      MDU_FIN:  w_next = MDU_IDLE;
      default:  w_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_prod      <= '0;
      r_opb       <= '0;
      r_a_raw     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0_pend <= 1'b0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_cnt       <= '0;
            r_is_div    <= w_is_div;
            r_a_raw     <= bus.a;
            r_prod      <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_opb       <= w_is_div ? w_abs_b : w_abs_a;
            r_neg_q     <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r     <= w_signed && bus.a[WIDTH-1];
            r_div0_pend <= w_is_div && (bus.b == '0);
          end else if (w_take && bus.op == MDU_MTHI) begin
            r_hi <= bus.a;
          end else if (w_take && bus.op == MDU_MTLO) begin
            r_lo <= bus.a;
          end
        end
        MDU_RUN: begin
          if (!bus.flush) begin
            r_cnt  <= r_cnt + 1'b1;
            r_prod <= r_is_div ? w_div_next : w_mul_next;
          end
        end
        MDU_FIN: begin
          if (!bus.flush) begin
            r_done <= 1'b1;
            r_div0 <= r_div0_pend;
            if (r_div0_pend) begin
              r_hi <= r_a_raw;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_prod_fix[WIDTH-1:0];
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != MDU_IDLE);
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized and directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int errs = 0;
  int chks = 0;
  bit cmp_on = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result as {div0, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULT: begin
        p = sa * sb;
        return {1'b0, p};
      end
      MDU_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == MDU_DIV) return {1'b0, 32'(sa % sb), 32'(sa / sb)};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Transaction-level model: an accepted op keeps the unit busy W+1 cycles, then lands its result.
  int          m_left;
  logic [64:0] m_res;
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_div0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_res  <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_div0 <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      if (m_left > 0) begin
        if (bus.flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
            m_done <= 1'b1;
            m_div0 <= m_res[64];
          end
        end
      end else if (bus.start && !bus.flush) begin
        if (bus.op < 3'd4) begin
          m_res  <= calc(bus.op, bus.a, bus.b);
          m_left <= W + 1;
        end else if (bus.op == MDU_MTHI) m_hi <= bus.a;
        else if (bus.op == MDU_MTLO) m_lo <= bus.a;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      chks++;
      if ({bus.busy, bus.done, bus.div0, bus.hi, bus.lo} !== {(m_left != 0), m_done, m_div0, m_hi, m_lo}) begin
        errs++;
        $display("FAIL cycle @%0t: busy/done/div0/hi/lo got %b %b %b %h %h expected %b %b %b %h %h",
                 $time, bus.busy, bus.done, bus.div0, bus.hi, bus.lo,
                 (m_left != 0), m_done, m_div0, m_hi, m_lo);
      end
    end
  end

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(string name, logic [31:0] eh, logic [31:0] el, logic ed, int poke_at);
    int n, nb;
    n  = 0;
    nb = bus.busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == poke_at) begin
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        n = k;
        break;
      end
      if (bus.busy) nb++;
    end
    check({name, " done_latency"}, 64'(n), 64'd33);
    check({name, " busy_cycles"}, 64'(nb), 64'd33);
    check({name, " hi"}, 64'(bus.hi), 64'(eh));
    check({name, " lo"}, 64'(bus.lo), 64'(el));
    check({name, " div0"}, 64'(bus.div0), 64'(ed));
  endtask

  task automatic expect_quiet(string name, int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check({name, " no_activity"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    int          fl_at, still;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy/done/div0", {61'd0, bus.busy, bus.done, bus.div0}, 64'd0);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_done("divu", 32'd1, 32'h7FFF_FFFC, 1'b0, 0);
    issue(MDU_DIVU, 32'd7, 32'd0);
    wait_done("div_by_zero", 32'd7, 32'hFFFF_FFFF, 1'b1, 0);
    @(posedge clk);
    #1;
    check("div0 cleared", 64'(bus.div0), 64'd0);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("overflow", 32'd0, 32'h8000_0000, 1'b0, 0);
    issue(MDU_MULTU, 32'd6, 32'd7);
    wait_done("back_to_back", 32'd0, 32'd42, 1'b0, 0);
    issue(MDU_MULTU, 32'd3, 32'd5);
    wait_done("ignored_start", 32'd0, 32'd15, 1'b0, 10);

    issue(MDU_MTHI, 32'h1234, 32'd0);
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi busy", 64'(bus.busy), 64'd0);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    expect_quiet("flush", 40);
    check("flush hi/lo kept", {bus.hi, bus.lo}, {32'h1234, 32'd15});

    bus.flush = 1'b1;
    issue(MDU_MULTU, 32'd2, 32'd3);
    bus.flush = 1'b0;
    expect_quiet("flush_with_start", 40);

    issue(MDU_MULT, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("async reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(MDU_MULTU, 32'd6, 32'd7);
    wait_done("after_reset", 32'd0, 32'd42, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      issue(op, ra, rb);
      fl_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 34) : -1;
      for (int k = 0; k < 50; k++) begin
        if (!bus.busy) break;
        if (k == fl_at) bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
      end
      still = bus.busy ? 1 : 0;
      check("random op settles", 64'(still), 64'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    @(posedge clk);
    #1;
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit beside the single-cycle ALU in EX, generalised to WIDTH bits.
- Executes MIPS MULT/MULTU/DIV/DIVU one bit per cycle and owns the HI/LO architectural registers; also performs MTHI/MTLO.
- Start/busy/done handshake. Hazard logic stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal range 4..64.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  3  operation code (package constants), sampled with start
- a  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
- b  in  WIDTH  rt operand (multiplier/divisor)
- flush  in  1  cancel any in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO just updated by a mul/div
- div0  out  1  valid with done; last divide had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div0=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately with no partial HI/LO write.
- States: IDLE, RUN, FIN.
- IDLE, start=1, flush=0:
  - MULT/MULTU/DIV/DIVU: latch |a|,|b| (signed ops) or a,b (unsigned ops); record result signs; counter=0; go to RUN; busy=1 from the next cycle.
  - MTHI/MTLO: write hi (or lo) = a on that edge; stay IDLE; no busy, no done.
  - Codes 6/7: no-op.
- RUN: one iteration per edge, counter++.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per edge.
  - The edge with counter==WIDTH-1 moves to FIN.
- FIN edge: apply sign correction; write hi/lo; done=1 and div0 set for one cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle that begins WIDTH+1 edges after the accepting edge. busy=1 for exactly WIDTH+1 cycles. hi/lo are valid in the same cycle done=1.
- A new start in the done cycle is accepted (back-to-back).
- Multiply result: {hi,lo} = full 2*WIDTH product. Signed: product is negated iff a and b signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
  - Quotient truncates toward zero.
- Divide by zero (b==0, DIV or DIVU): lo = all ones, hi = a (original, uncorrected). Sign correction bypassed; div0=1.
- Signed overflow (a = most-negative value, b = -1): lo = most-negative value, hi = 0, div0=0.
- flush=1: from RUN or FIN, return to IDLE on the next edge. busy=0; no done; hi/lo unchanged.
- flush and start in the same cycle: flush wins; start ignored.
- start while busy=1: ignored, op/a/b not sampled.
- div0 stays at 0 on non-divide completions and is cleared to 0 one cycle after done.

Decomposition:
- Shared package/defines file (ctrl_encode_def): MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5. Also state encodings MDU_IDLE/MDU_RUN/MDU_FIN.
- One natural sub-module, mdu_sign_fix: combinational absolute-value-in and negate-out helper, instantiated for operands and results.
- Counter, FSM and shift registers stay in mul_div_unit.

Test Plan (WIDTH=32):
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=5 → after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1. busy high exactly 33 cycles.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, div0=0. Unsigned divide: DIVU a=0xFFFFFFF9, b=2 → lo=0x7FFFFFFC, hi=1.
- Divide by zero: DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7, div0=1 for one cycle. Overflow: DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Flush: MTHI a=0x1234 then MULTU a=b=0xFFFFFFFF, flush at RUN cycle 10 → busy=0 next cycle, no done, hi=0x1234. Flush+start in the same cycle → no operation starts.
- Back-to-back and ignored starts: start a MULTU 6*7 in the done cycle of a prior op → accepted, lo=42. A start issued mid-RUN → ignored, result of the first op intact.
- Async reset: assert rst_n=0 mid-RUN between clock edges → busy, done, hi and lo read 0 immediately. After release, the first start behaves normally.
